// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU layer scheduler.
// State encoding, bus widths and default sequencing parameters.
package tpu_pkg;

    localparam int MEM_ADDR_W     = 12;
    localparam int VEC_W          = 1024;
    localparam int LAYER_W        = 2;
    localparam int DEF_NUM_LAYERS = 3;
    localparam int DEF_WDOG_LIMIT = 2048;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENG_RST = 3'd1,
        S_RUN     = 3'd2,
        S_NEXT    = 3'd3,
        S_FINISH  = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

endpackage

// File: rtl/tpu_grant_mux.sv
// Selects the granted engine's address and MultAdd operand slices.
// Outputs are all-zero when no engine is granted.
module tpu_grant_mux
    import tpu_pkg::*;
#(
    parameter int NUM_LAYERS = DEF_NUM_LAYERS
) (
    input  logic                             en,
    input  logic [LAYER_W-1:0]               sel,
    input  logic [NUM_LAYERS*MEM_ADDR_W-1:0] eng_addr,
    input  logic [NUM_LAYERS*VEC_W-1:0]      eng_data1,
    input  logic [NUM_LAYERS*VEC_W-1:0]      eng_data2,
    output logic [MEM_ADDR_W-1:0]            addr,
    output logic [VEC_W-1:0]                 data1,
    output logic [VEC_W-1:0]                 data2
);

    always_comb begin
        addr  = '0;
        data1 = '0;
        data2 = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (en && (int'(sel) == k)) begin
                addr  = eng_addr[k*MEM_ADDR_W +: MEM_ADDR_W];
                data1 = eng_data1[k*VEC_W +: VEC_W];
                data2 = eng_data2[k*VEC_W +: VEC_W];
            end
        end
    end

endmodule

// File: rtl/tpu_layer_scheduler.sv
// Sequences NUM_LAYERS engines over a shared memory/MultAdd path,
// with a per-layer watchdog and sticky overflow/error reporting.
module tpu_layer_scheduler
    import tpu_pkg::*;
#(
    parameter int NUM_LAYERS = DEF_NUM_LAYERS,
    parameter int WDOG_LIMIT = DEF_WDOG_LIMIT
) (
    input  logic                             clk,
    input  logic                             iRst,
    input  logic                             start,
    input  logic [NUM_LAYERS-1:0]            eng_done,
    input  logic [NUM_LAYERS-1:0]            eng_overflow,
    input  logic [NUM_LAYERS*MEM_ADDR_W-1:0] eng_addr,
    input  logic [NUM_LAYERS*VEC_W-1:0]      eng_data1,
    input  logic [NUM_LAYERS*VEC_W-1:0]      eng_data2,
    output logic [NUM_LAYERS-1:0]            eng_ena,
    output logic [NUM_LAYERS-1:0]            eng_rst_n,
    output logic [MEM_ADDR_W-1:0]            mem_addr,
    output logic [VEC_W-1:0]                 mult_data1,
    output logic [VEC_W-1:0]                 mult_data2,
    output logic                             busy,
    output logic [LAYER_W-1:0]               cur_layer,
    output logic                             done,
    output logic                             overflow,
    output logic                             error
);

    localparam int WDOG_W =
        (WDOG_LIMIT > 1) ? $clog2(WDOG_LIMIT) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST =
        WDOG_W'(WDOG_LIMIT - 1);
    localparam logic [LAYER_W-1:0] LAST_LAYER =
        LAYER_W'(NUM_LAYERS - 1);

    state_t                 state, state_d;
    logic [LAYER_W-1:0]     layer_d;
    logic [WDOG_W-1:0]      wdog, wdog_d;
    logic                   ovf_d, err_d;
    logic                   cur_done, cur_ovf;
    logic                   grant_d;
    logic [NUM_LAYERS-1:0]  onehot_d;
    logic [MEM_ADDR_W-1:0]  mux_addr;
    logic [VEC_W-1:0]       mux_data1, mux_data2;

    // Only the granted engine's done/overflow is ever looked at.
    always_comb begin
        cur_done = 1'b0;
        cur_ovf  = 1'b0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (int'(cur_layer) == k) begin
                cur_done = eng_done[k];
                cur_ovf  = eng_overflow[k];
            end
        end
    end

    always_comb begin
        state_d = state;
        layer_d = cur_layer;
        wdog_d  = wdog;
        ovf_d   = overflow;
        err_d   = error;
        unique case (state)
            S_IDLE, S_ERROR: begin
                if (start) begin
                    state_d = S_ENG_RST;
                    layer_d = '0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            S_ENG_RST: begin
                state_d = S_RUN;
                wdog_d  = '0;
            end
            S_RUN: begin
                if (cur_done) begin
                    state_d = S_NEXT;
                    ovf_d   = overflow | cur_ovf;
                end else if (wdog == WDOG_LAST) begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                end else begin
                    wdog_d = wdog + WDOG_W'(1);
                end
            end
            S_NEXT: begin
                if (cur_layer == LAST_LAYER) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = S_ENG_RST;
                    layer_d = cur_layer + LAYER_W'(1);
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        grant_d = (state_d == S_ENG_RST) || (state_d == S_RUN);
        for (int k = 0; k < NUM_LAYERS; k++) begin
            onehot_d[k] = (int'(layer_d) == k);
        end
    end

    tpu_grant_mux #(
        .NUM_LAYERS (NUM_LAYERS)
    ) u_mux (
        .en        (grant_d),
        .sel       (layer_d),
        .eng_addr  (eng_addr),
        .eng_data1 (eng_data1),
        .eng_data2 (eng_data2),
        .addr      (mux_addr),
        .data1     (mux_data1),
        .data2     (mux_data2)
    );

    always_ff @(posedge clk) begin
        if (iRst) begin
            state     <= S_IDLE;
            cur_layer <= '0;
            wdog      <= '0;
            overflow  <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_d;
            cur_layer <= layer_d;
            wdog      <= wdog_d;
            overflow  <= ovf_d;
            error     <= err_d;
        end
    end

    // Outputs are decoded from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (iRst) begin
            eng_ena    <= '0;
            eng_rst_n  <= '1;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_addr   <= '0;
            mult_data1 <= '0;
            mult_data2 <= '0;
        end else begin
            eng_ena    <= grant_d ? onehot_d : '0;
            eng_rst_n  <= (state_d == S_ENG_RST) ? ~onehot_d : '1;
            busy       <= (state_d == S_ENG_RST) ||
                          (state_d == S_RUN) ||
                          (state_d == S_NEXT);
            done       <= (state_d == S_FINISH);
            mem_addr   <= mux_addr;
            mult_data1 <= mux_data1;
            mult_data2 <= mux_data2;
        end
    end

endmodule

// File: tb/tb_tpu_layer_scheduler.sv
// Scoreboard bench for tpu_layer_scheduler: directed sequences push
// expected grant/run/done/error events, a monitor pops and compares.
module tb_tpu_layer_scheduler;
    import tpu_pkg::*;

    localparam int NL = 3;
    localparam int WD = 16;

    localparam logic [3:0] K_RST  = 4'd1;
    localparam logic [3:0] K_END  = 4'd2;
    localparam logic [3:0] K_DONE = 4'd3;
    localparam logic [3:0] K_ERR  = 4'd4;

    typedef struct packed {
        logic [3:0]  kind;
        logic [3:0]  layer;
        logic [15:0] val;
        logic        ovf;
        logic        err;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     iRst;
    logic                     start;
    logic [NL-1:0]            eng_done;
    logic [NL-1:0]            eng_overflow;
    logic [NL*MEM_ADDR_W-1:0] eng_addr;
    logic [NL*VEC_W-1:0]      eng_data1;
    logic [NL*VEC_W-1:0]      eng_data2;
    logic [NL-1:0]            eng_ena;
    logic [NL-1:0]            eng_rst_n;
    logic [MEM_ADDR_W-1:0]    mem_addr;
    logic [VEC_W-1:0]         mult_data1;
    logic [VEC_W-1:0]         mult_data2;
    logic                     busy;
    logic [LAYER_W-1:0]       cur_layer;
    logic                     done;
    logic                     overflow;
    logic                     error;

    tpu_layer_scheduler #(
        .NUM_LAYERS (NL),
        .WDOG_LIMIT (WD)
    ) dut (
        .clk          (clk),
        .iRst         (iRst),
        .start        (start),
        .eng_done     (eng_done),
        .eng_overflow (eng_overflow),
        .eng_addr     (eng_addr),
        .eng_data1    (eng_data1),
        .eng_data2    (eng_data2),
        .eng_ena      (eng_ena),
        .eng_rst_n    (eng_rst_n),
        .mem_addr     (mem_addr),
        .mult_data1   (mult_data1),
        .mult_data2   (mult_data2),
        .busy         (busy),
        .cur_layer    (cur_layer),
        .done         (done),
        .overflow     (overflow),
        .error        (error)
    );

    int             n_chk = 0;
    int             n_fail = 0;
    ev_t            exp_q[$];
    int             lat[NL];
    int             cnt[NL];
    logic [NL-1:0]  extra;
    logic           quiet;
    logic [11:0]    addr_tab[NL];
    logic [1023:0]  d1_tab[NL];
    logic [1023:0]  d2_tab[NL];

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_w(input string nm,
                         input logic [1023:0] act,
                         input logic [1023:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got ..%h expected ..%h",
                     nm, act[31:0], exp[31:0]);
        end
    endtask

    task automatic push(input logic [3:0] k, input int l,
                        input int v, input logic o, input logic e);
        ev_t x;
        x.kind  = k;
        x.layer = 4'(l);
        x.val   = 16'(v);
        x.ovf   = o;
        x.err   = e;
        exp_q.push_back(x);
    endtask

    task automatic push_layer(input int l, input int len, input logic o);
        push(K_RST, l, 'h400 + l, o, 1'b0);
        push(K_END, l, len, 1'b0, 1'b0);
    endtask

    task automatic got(input logic [3:0] k, input int l,
                       input int v, input logic o, input logic e);
        ev_t a, x;
        a.kind  = k;
        a.layer = 4'(l);
        a.val   = 16'(v);
        a.ovf   = o;
        a.err   = e;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL event: unexpected k=%0d l=%0d v=%0h o=%b e=%b",
                     a.kind, a.layer, a.val, a.ovf, a.err);
        end else begin
            x = exp_q.pop_front();
            if (a !== x) begin
                n_fail++;
                $display({"FAIL event: got k=%0d l=%0d v=%0h o=%b e=%b",
                          " expected k=%0d l=%0d v=%0h o=%b e=%b"},
                         a.kind, a.layer, a.val, a.ovf, a.err,
                         x.kind, x.layer, x.val, x.ovf, x.err);
            end
        end
    endtask

    // Engine model: done rises once lat[k] RUN cycles have elapsed.
    always @(posedge clk) begin
        for (int k = 0; k < NL; k++) begin
            if (iRst || !eng_rst_n[k]) cnt[k] <= 0;
            else if (eng_ena[k]) cnt[k] <= cnt[k] + 1;
        end
    end

    always_comb begin
        eng_done = extra;
        for (int k = 0; k < NL; k++) begin
            if (lat[k] != 0 && cnt[k] >= lat[k]) eng_done[k] = 1'b1;
        end
    end

    logic [NL-1:0] prev_ena;
    int            prev_layer;
    logic          prev_err;
    int            run_len;

    always @(negedge clk) begin
        int idx;
        if (iRst || quiet) begin
            prev_ena = '0;
            prev_err = 1'b0;
            run_len  = 0;
        end else begin
            chk("ena_onehot", 64'($onehot0(eng_ena)), 64'd1);
            if (prev_ena != '0 && eng_ena != '0)
                chk("ena_adjacent", 64'(eng_ena), 64'(prev_ena));
            idx = -1;
            for (int k = 0; k < NL; k++) if (eng_ena[k]) idx = k;
            if (idx < 0) begin
                chk("addr_idle", 64'(mem_addr), 64'd0);
                chk_w("data1_idle", mult_data1, '0);
            end else begin
                chk("ena_layer", 64'(eng_ena),
                    64'(NL'(1) << cur_layer));
                chk("addr_grant", 64'(mem_addr), 64'(addr_tab[idx]));
                chk_w("data1_grant", mult_data1, d1_tab[idx]);
                chk_w("data2_grant", mult_data2, d2_tab[idx]);
            end
            if (eng_rst_n != '1)
                got(K_RST, int'(cur_layer), int'(mem_addr),
                    overflow, error);
            if (eng_ena != '0 && eng_rst_n == '1) run_len++;
            if (prev_ena != '0 && eng_ena == '0) begin
                got(K_END, prev_layer, run_len, 1'b0, 1'b0);
                run_len = 0;
            end
            if (done)
                got(K_DONE, int'(cur_layer), int'(busy), overflow, error);
            if (error && !prev_err)
                got(K_ERR, int'(cur_layer), int'({busy, eng_ena}),
                    overflow, error);
            prev_ena   = eng_ena;
            prev_layer = int'(cur_layer);
            prev_err   = error;
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_q(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        iRst         = 1'b1;
        start        = 1'b0;
        quiet        = 1'b0;
        extra        = '0;
        eng_overflow = '0;
        lat          = '{4, 8, 12};
        for (int k = 0; k < NL; k++) begin
            addr_tab[k] = 12'h400 + 12'(k);
            d1_tab[k]   = {32{32'hA5A5_0000 + 32'(k)}};
            d2_tab[k]   = ~d1_tab[k];
            eng_addr[k*MEM_ADDR_W +: MEM_ADDR_W] = addr_tab[k];
            eng_data1[k*VEC_W +: VEC_W] = d1_tab[k];
            eng_data2[k*VEC_W +: VEC_W] = d2_tab[k];
        end

        repeat (3) @(negedge clk);
        chk("rst_ena", 64'(eng_ena), 64'd0);
        chk("rst_rstn", 64'(eng_rst_n), 64'b111);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_flags", 64'({busy, done, overflow, error, cur_layer}),
            64'd0);
        chk_w("rst_data2", mult_data2, '0);
        iRst = 1'b0;
        @(negedge clk);

        // Plain sequence; a second start mid-run must be ignored.
        push_layer(0, 5, 1'b0);
        push_layer(1, 9, 1'b0);
        push_layer(2, 13, 1'b0);
        push(K_DONE, 2, 0, 1'b0, 1'b0);
        pulse_start();
        repeat (6) @(negedge clk);
        pulse_start();
        wait_q(300);
        repeat (3) @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_ena", 64'(eng_ena), 64'd0);

        // Overflow from engine 1 only, sticky through done.
        eng_overflow = 3'b010;
        push_layer(0, 5, 1'b0);
        push_layer(1, 9, 1'b0);
        push_layer(2, 13, 1'b1);
        push(K_DONE, 2, 0, 1'b1, 1'b0);
        pulse_start();
        wait_q(300);
        repeat (4) @(negedge clk);
        chk("ovf_hold", 64'(overflow), 64'd1);
        eng_overflow = '0;

        // Overflow cleared by start; stray done on idle engines ignored.
        extra = 3'b110;
        push_layer(0, 5, 1'b0);
        push_layer(1, 1, 1'b0);
        push_layer(2, 1, 1'b0);
        push(K_DONE, 2, 0, 1'b0, 1'b0);
        pulse_start();
        wait_q(300);
        extra = '0;
        repeat (2) @(negedge clk);

        // Engine 2 hangs: watchdog fires after WD RUN cycles.
        lat = '{4, 4, 0};
        push_layer(0, 5, 1'b0);
        push_layer(1, 5, 1'b0);
        push(K_RST, 2, 'h402, 1'b0, 1'b0);
        push(K_END, 2, 16, 1'b0, 1'b0);
        push(K_ERR, 2, 0, 1'b0, 1'b1);
        pulse_start();
        wait_q(300);
        repeat (3) @(negedge clk);
        chk("err_flag", 64'({error, busy, eng_ena}), 64'b1_0_000);

        // Recovery from ERROR back to layer 0.
        lat[2] = 4;
        push_layer(0, 5, 1'b0);
        push_layer(1, 5, 1'b0);
        push_layer(2, 5, 1'b0);
        push(K_DONE, 2, 0, 1'b0, 1'b0);
        pulse_start();
        wait_q(300);
        repeat (2) @(negedge clk);
        chk("err_cleared", 64'(error), 64'd0);

        // Done on the last watchdog cycle wins over the timeout.
        lat[2] = 15;
        push_layer(0, 5, 1'b0);
        push_layer(1, 5, 1'b0);
        push_layer(2, 16, 1'b0);
        push(K_DONE, 2, 0, 1'b0, 1'b0);
        pulse_start();
        wait_q(300);
        repeat (2) @(negedge clk);

        // Reset in the middle of layer 1.
        lat = '{4, 20, 4};
        push_layer(0, 5, 1'b0);
        push(K_RST, 1, 'h401, 1'b0, 1'b0);
        pulse_start();
        wait_q(100);
        repeat (4) @(negedge clk);
        chk("mid_layer", 64'({cur_layer, eng_ena}), 64'({2'd1, 3'b010}));
        @(negedge clk);
        quiet = 1'b1;
        iRst  = 1'b1;
        @(negedge clk);
        chk("mrst_ena", 64'(eng_ena), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_addr", 64'(mem_addr), 64'd0);
        chk("mrst_state", 64'({cur_layer, eng_rst_n}), 64'({2'd0, 3'b111}));
        iRst = 1'b0;
        @(negedge clk);
        quiet = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'd0);

        // Reset and start together: reset wins.
        iRst  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        iRst  = 1'b0;
        start = 1'b0;
        chk("rs_ena", 64'(eng_ena), 64'd0);
        chk("rs_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("rs_idle", 64'({busy, eng_ena}), 64'd0);

        // Normal run after reset.
        lat = '{4, 8, 12};
        push_layer(0, 5, 1'b0);
        push_layer(1, 9, 1'b0);
        push_layer(2, 13, 1'b0);
        push(K_DONE, 2, 0, 1'b0, 1'b0);
        pulse_start();
        wait_q(300);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
